ram_port_arbiter: RTL and testbench
===================================

Name: ram_port_arbiter

Overview:
- Shares the single-port 64K system BRAM (1-cycle synchronous read) between two requesters:
  - the Z80 CPU bus;
  - a DMA requester, e.g. the serial program loader or the screen/snapshot dumper.
- The CPU has priority. DMA is protected against starvation by a wait-state guard.
- A lock input gives DMA exclusive access for bulk uploads.
- The block also enforces CPU write protection of the ROM region.
- Sits between the CPU address decode and the BRAM address/write port.

Parameters:
- ADDR_W, 16, RAM address width.
- DATA_W, 8, RAM data width.
- ROM_TOP, 16'h2000, CPU writes to addresses below this are suppressed. DMA writes are not.
- STARVE_LIMIT, 4, consecutive cycles a pending DMA request may lose to the CPU before it is forced through. Range 1..15.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous, active-low reset.
- cpu_req  in  1  CPU memory cycle active (decoded rd_ram|wr_ram). Held stable while cpu_wait_n is low.
- cpu_we  in  1  CPU write.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_rdata  out  DATA_W  read data to CPU.
- cpu_wait_n  out  1  low = stall the CPU (drives tv80 wait_n).
- dma_req  in  1  DMA transfer request. Held with addr/we/wdata stable until dma_ack.
- dma_we  in  1  DMA write.
- dma_addr  in  ADDR_W  DMA address.
- dma_wdata  in  DATA_W  DMA write data.
- dma_lock  in  1  exclusive DMA mode. The CPU is stalled on any access.
- dma_ack  out  1  one-cycle pulse: the request was issued to RAM this cycle.
- dma_rdata  out  DATA_W  DMA read data, valid when dma_rvalid is high.
- dma_rvalid  out  1  pulse, one cycle after a DMA read ack.
- ram_addr  out  ADDR_W  to BRAM.
- ram_we  out  1  to BRAM.
- ram_wdata  out  DATA_W  to BRAM.
- ram_rdata  in  DATA_W  from BRAM. Data for the address issued in the previous cycle.

Behaviour:

Grant decision (combinational, evaluated every cycle):
- force = (starve_cnt == STARVE_LIMIT) | dma_lock.
- If reset_n low: grant = NONE.
- Else if dma_req & (!cpu_req | force): grant = DMA.
- Else if cpu_req & !dma_lock: grant = CPU.
- Else: grant = NONE.

RAM port:
- grant DMA: ram_addr = dma_addr, ram_we = dma_we, ram_wdata = dma_wdata.
- grant CPU: ram_addr = cpu_addr, ram_wdata = cpu_wdata, ram_we = cpu_we & (cpu_addr >= ROM_TOP).
- grant NONE: ram_addr = cpu_addr, ram_we = 0.
- A suppressed ROM write still counts as a granted CPU cycle. cpu_wait_n stays high for it.

CPU handshake:
- cpu_wait_n = !(cpu_req & grant != CPU). It is combinational.
- cpu_rdata = ram_rdata, passed through.
- The CPU samples data after wait_n is released. A CPU read granted in cycle N has valid data in N+1.

DMA handshake:
- dma_ack = (grant == DMA).
- dma_rvalid is registered: set in N+1 when cycle N had a DMA read grant (dma_ack & !dma_we), else 0.
- dma_rdata = ram_rdata. It is meaningful only while dma_rvalid is high.

Starvation counter (starve_cnt, 4 bits, registered):
- Clears to 0 on a DMA grant, or when dma_req is low.
- Increments by 1 when dma_req is high and grant == CPU, saturating at STARVE_LIMIT.
- When forced, DMA takes exactly one cycle. The counter returns to 0, and the CPU stalls for that one cycle only.

Reset:
- On the clock edge with reset_n low: starve_cnt = 0, dma_rvalid = 0.
- While reset_n is low: ram_we = 0, dma_ack = 0, cpu_wait_n = 1.

Boundary conditions:
- Simultaneous requests with no force: the CPU wins and dma_ack stays 0.
- dma_lock asserted mid-sequence: it takes effect the same cycle. The CPU stalls indefinitely until it drops.
- dma_req dropped before ack: the request is abandoned with no RAM effect and starve_cnt clears.
- Reset mid-DMA-read: dma_rvalid is not asserted for the interrupted read.
- Back-to-back DMA reads (dma_req held, address changing after each ack): throughput is 1 per cycle when the CPU is idle.

Test Plan:
1. CPU only: write 0x5A to 0x4000, then read 0x4000 → ram_we=1 in the write cycle, cpu_wait_n always 1, cpu_rdata=0x5A one cycle after the read grant.
2. ROM protect: CPU writes 0xFF to 0x1234 → ram_we=0, cpu_wait_n=1. A DMA write of 0x77 to 0x1234 followed by a DMA read → dma_rvalid pulse with dma_rdata=0x77.
3. Contention: cpu_req held continuously (its own sequence of reads), dma_req held from cycle 0 with STARVE_LIMIT=4 → CPU granted in cycles 0-3, dma_ack and cpu_wait_n=0 in cycle 4 only, starve_cnt back to 0 in cycle 5.
4. Lock: dma_lock=1 with cpu_req=1 for 20 cycles and 8 DMA writes to 0x8000-0x8007 → cpu_wait_n=0 throughout, 8 dma_ack pulses. Lock released → CPU granted the next cycle.
5. Reset mid-operation: reset_n low on the cycle after a DMA read ack → dma_rvalid=0, ram_we=0, cpu_wait_n=1 while in reset, starve_cnt=0 after release.
6. Idle: no requests → ram_we=0, dma_ack=0, dma_rvalid=0, cpu_wait_n=1.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// Shares the single-port system BRAM between the Z80 bus and a DMA requester.
// CPU has priority; a starvation guard and a lock input let DMA through.
module ram_port_arbiter #(
  parameter int                ADDR_W       = 16,
  parameter int                DATA_W       = 8,
  parameter logic [ADDR_W-1:0] ROM_TOP      = 16'h2000,
  parameter int                STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_wait_n,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  input  logic              dma_lock,
  output logic              dma_ack,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_rvalid,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_CPU  = 2'd1,
    GNT_DMA  = 2'd2
  } grant_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  grant_t      grant_s;
  logic        force_s;
  logic [3:0]  starve_cnt_r;
  logic        dma_rvalid_r;

  // Grant decision: DMA only wins against an active CPU cycle when forced.
  always_comb begin
    force_s = (starve_cnt_r == LIMIT) | dma_lock;
    grant_s = GNT_NONE;
    if (!reset_n) begin
      grant_s = GNT_NONE;
    end else if (dma_req && (!cpu_req || force_s)) begin
      grant_s = GNT_DMA;
    end else if (cpu_req && !dma_lock) begin
      grant_s = GNT_CPU;
    end else begin
      grant_s = GNT_NONE;
    end
  end

  // RAM port mux; CPU writes into the ROM window are dropped but still granted.
  always_comb begin
    ram_addr  = cpu_addr;
    ram_wdata = cpu_wdata;
    ram_we    = 1'b0;
    case (grant_s)
      GNT_DMA: begin
        ram_addr  = dma_addr;
        ram_wdata = dma_wdata;
        ram_we    = dma_we;
      end
      GNT_CPU: begin
        ram_addr  = cpu_addr;
        ram_wdata = cpu_wdata;
        ram_we    = cpu_we & (cpu_addr >= ROM_TOP);
      end
      default: begin
        ram_addr  = cpu_addr;
        ram_wdata = cpu_wdata;
        ram_we    = 1'b0;
      end
    endcase
  end

  assign cpu_wait_n = !reset_n | !(cpu_req & (grant_s != GNT_CPU));
  assign cpu_rdata  = ram_rdata;
  assign dma_ack    = (grant_s == GNT_DMA);
  assign dma_rdata  = ram_rdata;
  // Gated so a read interrupted by reset never reports valid data.
  assign dma_rvalid = dma_rvalid_r & reset_n;

  // Starvation counter and DMA read-valid pipeline stage.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      starve_cnt_r <= 4'd0;
      dma_rvalid_r <= 1'b0;
    end else begin
      dma_rvalid_r <= (grant_s == GNT_DMA) & !dma_we;
      if ((grant_s == GNT_DMA) || !dma_req) begin
        starve_cnt_r <= 4'd0;
      end else if ((grant_s == GNT_CPU) && (starve_cnt_r < LIMIT)) begin
        starve_cnt_r <= starve_cnt_r + 4'd1;
      end else begin
        starve_cnt_r <= starve_cnt_r;
      end
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Randomised bench for ram_port_arbiter with a BRAM model and a
// rule-level reference model (integer starvation count, shadow memory).
module tb_ram_port_arbiter;
  localparam int          STARVE_LIMIT = 4;
  localparam logic [15:0] ROM_TOP      = 16'h2000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cpu_req, cpu_we, dma_req, dma_we, dma_lock;
  logic [15:0] cpu_addr, dma_addr, ram_addr;
  logic [7:0]  cpu_wdata, dma_wdata, ram_wdata, ram_rdata, cpu_rdata, dma_rdata;
  logic        cpu_wait_n, dma_ack, dma_rvalid, ram_we;

  ram_port_arbiter #(
    .ADDR_W(16), .DATA_W(8), .ROM_TOP(ROM_TOP), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_wait_n(cpu_wait_n),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_lock(dma_lock), .dma_ack(dma_ack), .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // BRAM: one-cycle synchronous read.
  bit [7:0] mem [0:65535];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  // Reference model state
  int       starve;
  int       g;          // 0 none, 1 cpu, 2 dma
  bit       p_cpu_rd, p_dma_rd;
  bit [7:0] p_data;
  bit [7:0] shadow [0:65535];
  int       n_pass, n_checks;

  bit       o_ack, o_wait, o_we, o_rvalid;
  logic [7:0] o_cpu_rdata, o_dma_rdata;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Called at a falling edge with inputs applied; checks, then advances one clock.
  task automatic cycle();
    bit          frc, e_we, e_wait, e_rvalid;
    logic [15:0] e_addr;
    logic [7:0]  e_wdata;
    #1;
    frc = (starve == STARVE_LIMIT) || dma_lock;
    if (!reset_n)                          g = 0;
    else if (dma_req && (!cpu_req || frc)) g = 2;
    else if (cpu_req && !dma_lock)         g = 1;
    else                                   g = 0;
    e_addr  = (g == 2) ? dma_addr : cpu_addr;
    e_wdata = (g == 2) ? dma_wdata : cpu_wdata;
    e_we    = (g == 2) ? dma_we : ((g == 1) ? (cpu_we && cpu_addr >= ROM_TOP) : 1'b0);
    e_wait  = !reset_n || !(cpu_req && g != 1);
    e_rvalid = p_dma_rd && reset_n;
    check("dma_ack", 32'(dma_ack), 32'(g == 2));
    check("cpu_wait_n", 32'(cpu_wait_n), 32'(e_wait));
    check("ram_we", 32'(ram_we), 32'(e_we));
    check("ram_addr", 32'(ram_addr), 32'(e_addr));
    if (e_we) check("ram_wdata", 32'(ram_wdata), 32'(e_wdata));
    check("dma_rvalid", 32'(dma_rvalid), 32'(e_rvalid));
    if (e_rvalid) check("dma_rdata", 32'(dma_rdata), 32'(p_data));
    if (p_cpu_rd && reset_n) check("cpu_rdata", 32'(cpu_rdata), 32'(p_data));
    o_ack = dma_ack; o_wait = cpu_wait_n; o_we = ram_we; o_rvalid = dma_rvalid;
    o_cpu_rdata = cpu_rdata; o_dma_rdata = dma_rdata;
    @(posedge clk);
    p_cpu_rd = (g == 1) && !cpu_we;
    p_dma_rd = (g == 2) && !dma_we;
    p_data   = shadow[e_addr];
    if (e_we) shadow[e_addr] = e_wdata;
    if (!reset_n || g == 2 || !dma_req)        starve = 0;
    else if (g == 1 && starve < STARVE_LIMIT) starve++;
    @(negedge clk);
  endtask

  function automatic logic [15:0] rand_addr();
    if ($urandom_range(0, 3) == 0) return 16'h4000 + 16'($urandom_range(0, 15));
    return 16'h1FF0 + 16'($urandom_range(0, 31));
  endfunction

  int       acks, waith, k;
  bit [5:0] ack_v, wait_v;

  initial begin
    n_pass = 0; n_checks = 0; starve = 0; g = 0; p_cpu_rd = 0; p_dma_rd = 0; p_data = 8'h00;
    reset_n = 1'b0; cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h4000; cpu_wdata = 8'h11;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = 16'h0000; dma_wdata = 8'h00; dma_lock = 1'b0;
    @(negedge clk);
    cycle(); cycle();
    check("rst_rvalid", 32'(o_rvalid), 32'd0);
    check("rst_we", 32'(o_we), 32'd0);
    reset_n = 1'b1; cpu_req = 1'b0;
    cycle();

    // CPU write then read-back
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h4000; cpu_wdata = 8'h5A;
    cycle();
    check("t1_we", 32'(o_we), 32'd1);
    cpu_we = 1'b0;
    cycle();
    cpu_req = 1'b0;
    cycle();
    check("t1_rdata", 32'(o_cpu_rdata), 32'h5A);

    // ROM protection, then DMA write/read at the same address
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h1234; cpu_wdata = 8'hFF;
    cycle();
    check("t2_rom_we", 32'(o_we), 32'd0);
    check("t2_rom_wait", 32'(o_wait), 32'd1);
    cpu_req = 1'b0;
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 16'h1234; dma_wdata = 8'h77;
    cycle();
    dma_we = 1'b0;
    cycle();
    dma_req = 1'b0;
    cycle();
    check("t2_rvalid", 32'(o_rvalid), 32'd1);
    check("t2_rdata", 32'(o_dma_rdata), 32'h77);

    // Contention: forced DMA on the fifth cycle
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h4000;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h4000;
    for (int i = 0; i < 6; i++) begin
      cycle();
      ack_v[i] = o_ack; wait_v[i] = o_wait;
      if (o_ack) dma_req = 1'b0;
      if (g == 1) cpu_addr = cpu_addr + 16'd1;
    end
    check("t3_ack", 32'(ack_v), 32'(6'b010000));
    check("t3_wait", 32'(wait_v), 32'(6'b101111));
    cpu_req = 1'b0;
    cycle();

    // Lock: 8 DMA writes while the CPU is stalled
    dma_lock = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h4000;
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 16'h8000; dma_wdata = 8'hA0;
    acks = 0; waith = 0; k = 0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (o_wait) waith++;
      if (o_ack) begin
        acks++; k++;
        if (k < 8) begin
          dma_addr = 16'h8000 + 16'(k); dma_wdata = 8'hA0 + 8'(k);
        end else begin
          dma_req = 1'b0;
        end
      end
    end
    check("t4_acks", 32'(acks), 32'd8);
    check("t4_wait_high", 32'(waith), 32'd0);
    dma_lock = 1'b0;
    cycle();
    check("t4_release", 32'(o_wait), 32'd1);
    cpu_req = 1'b0; dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h8005;
    cycle();
    dma_req = 1'b0;
    cycle();
    check("t4_readback", 32'(o_dma_rdata), 32'hA5);

    // Reset in the cycle after a DMA read ack
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h8003;
    cycle();
    check("t5_ack", 32'(o_ack), 32'd1);
    dma_req = 1'b0; reset_n = 1'b0; cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h4000;
    cycle();
    check("t5_rvalid", 32'(o_rvalid), 32'd0);
    check("t5_we", 32'(o_we), 32'd0);
    check("t5_wait", 32'(o_wait), 32'd1);
    reset_n = 1'b1; cpu_req = 1'b0;
    cycle();

    // Idle
    cycle();
    check("t6_ack", 32'(o_ack), 32'd0);
    check("t6_we", 32'(o_we), 32'd0);
    check("t6_rvalid", 32'(o_rvalid), 32'd0);
    check("t6_wait", 32'(o_wait), 32'd1);

    // Random traffic honouring both handshakes
    for (int n = 0; n < 3000; n++) begin
      if (!(cpu_req && !o_wait)) begin
        cpu_req   = ($urandom_range(0, 2) != 0);
        cpu_we    = 1'($urandom_range(0, 1));
        cpu_addr  = rand_addr();
        cpu_wdata = 8'($urandom_range(0, 255));
      end
      if (!dma_req || o_ack) begin
        dma_req   = 1'($urandom_range(0, 1));
        dma_we    = 1'($urandom_range(0, 1));
        dma_addr  = rand_addr();
        dma_wdata = 8'($urandom_range(0, 255));
      end else if ($urandom_range(0, 15) == 0) begin
        dma_req = 1'b0;
      end
      if ($urandom_range(0, 15) == 0) dma_lock = ~dma_lock;
      reset_n = ($urandom_range(0, 99) != 0);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
